// File: rtl/mmio_stream_out.sv
// Memory-mapped TX FIFO: processor stores words at BASE_ADDR and they drain on a valid/ready stream.
// Define MMIO_HALT_EN to add a sticky kill register at word address 16'hFFFF.
module mmio_stream_out #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          DEPTH     = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    input  logic        WriteData,
    input  logic        ReadData,
    output logic [15:0] DataIn,
    output logic        Waitreq,
    output logic [15:0] TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        Halt
);
    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    typedef enum logic {IDLE, RD_DONE} readState_t;

    readState_t      state, nextState;
    logic [15:0]     offset;
    logic            sel, selTx, selStatus, selCtrl;
    logic [15:0]     fifoMem [DEPTH];
    logic [PtrW-1:0] rdPtr, wrPtr;
    logic [CntW-1:0] count;
    logic            full, empty, halted;
    logic            push, pop, flush, loadRead;
    logic [15:0]     regValue, readReg;
    logic [7:0]      count8;

    assign offset    = DataAddr - BASE_ADDR;
    assign sel       = offset < 16'd3;
    assign selTx     = sel && (offset == 16'd0);
    assign selStatus = sel && (offset == 16'd1);
    assign selCtrl   = sel && (offset == 16'd2);

    assign full    = (count == CntW'(DEPTH));
    assign empty   = (count == '0);
    assign TxValid = !empty;
    assign TxData  = fifoMem[rdPtr];

    // A push only happens when the slot is free; a full FIFO holds the writer on Waitreq instead.
    assign pop   = TxValid && TxReady;
    assign push  = WriteData && selTx && !full && !halted;
    assign flush = WriteData && selCtrl && DataOut[0];

`ifdef MMIO_HALT_EN
    logic haltReg;

    always_ff @(posedge Clock) begin
        if (!Reset)
            haltReg <= 1'b0;
        else if (WriteData && (DataAddr == 16'hFFFF))
            haltReg <= 1'b1;
    end

    assign halted = haltReg;
`else
    assign halted = 1'b0;
`endif

    assign Halt = halted;

    always_comb begin
        regValue = '0;
        count8   = 8'(count);
        if (selStatus)
            regValue = {count8, 6'b0, full, empty};
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PtrW'(1);
            if (pop)
                rdPtr <= rdPtr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && push)
            fifoMem[wrPtr] <= DataOut;
    end

    // Writes win over reads; a read costs one wait state while the register value is captured.
    always_comb begin
        nextState = state;
        Waitreq   = 1'b0;
        loadRead  = 1'b0;
        if (Reset) begin
            if (WriteData)
                Waitreq = selTx && full && !halted;
            case (state)
                IDLE: begin
                    if (ReadData && !WriteData && sel) begin
                        Waitreq   = 1'b1;
                        loadRead  = 1'b1;
                        nextState = RD_DONE;
                    end
                end
                RD_DONE: nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            readReg <= '0;
        end else begin
            state <= nextState;
            if (loadRead)
                readReg <= regValue;
        end
    end

    assign DataIn = (Reset && (state == RD_DONE)) ? readReg : 16'h0000;

endmodule

// File: tb/tb_mmio_stream_out.sv
// Bench for mmio_stream_out: directed bus/stream steps then random traffic, checked against a queue model.
// Build with MMIO_HALT_EN defined to also exercise the kill register.
module tb_mmio_stream_out;
    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hFF00;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataAddr, DataOut, DataIn, TxData;
    logic        WriteData, ReadData, Waitreq, TxValid, TxReady, Halt;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mQueue[$];
    bit          mRdDone, mHalted, mInit;
    logic [15:0] mRdVal;

    logic        obsWait, obsValid;
    logic [15:0] obsData, obsDataIn;

    mmio_stream_out #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DataAddr (DataAddr),
        .DataOut  (DataOut),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .DataIn   (DataIn),
        .Waitreq  (Waitreq),
        .TxData   (TxData),
        .TxValid  (TxValid),
        .TxReady  (TxReady),
        .Halt     (Halt)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check against the model just before the edge, then advance the model.
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic wr, input logic rd, input logic rdy, input logic rstn);
        logic [15:0] off, expDataIn, status;
        logic [7:0]  sz8;
        bit          sel, expWait, expValid, doPop, doPush, doFlush, haltHit;
        int          sz;
        DataAddr  = addr;
        DataOut   = wdata;
        WriteData = wr;
        ReadData  = rd;
        TxReady   = rdy;
        Reset     = rstn;
        #3;
        off = addr - BASE;
        sel = off < 16'd3;
        sz  = mQueue.size();
        sz8 = 8'(sz);
        status = {sz8, 6'b0, sz == DEPTH, sz == 0};
`ifdef MMIO_HALT_EN
        haltHit = wr && (addr == 16'hFFFF);
`else
        haltHit = 1'b0;
`endif
        expValid = sz != 0;
        if (!rstn)
            expWait = 1'b0;
        else if (wr)
            expWait = sel && off == 16'd0 && sz == DEPTH && !mHalted;
        else
            expWait = rd && sel && !mRdDone;
        expDataIn = (rstn && mRdDone) ? mRdVal : 16'h0000;

        obsWait   = Waitreq;
        obsValid  = TxValid;
        obsData   = TxData;
        obsDataIn = DataIn;
        if (mInit) begin
            checkOutput("Waitreq", {15'b0, obsWait}, {15'b0, expWait});
            checkOutput("TxValid", {15'b0, obsValid}, {15'b0, expValid});
            checkOutput("DataIn", obsDataIn, expDataIn);
            checkOutput("Halt", {15'b0, Halt}, {15'b0, mHalted});
            if (expValid)
                checkOutput("TxData", obsData, mQueue[0]);
        end

        @(posedge Clock);
        if (!rstn) begin
            mQueue.delete();
            mRdDone = 1'b0;
            mHalted = 1'b0;
            mInit   = 1'b1;
        end else begin
            doPop   = expValid && rdy;
            doFlush = wr && sel && off == 16'd2 && wdata[0];
            doPush  = wr && sel && off == 16'd0 && sz < DEPTH && !mHalted;
            if (doFlush)
                mQueue.delete();
            else begin
                if (doPop)
                    void'(mQueue.pop_front());
                if (doPush)
                    mQueue.push_back(wdata);
            end
            if (haltHit)
                mHalted = 1'b1;
            if (mRdDone)
                mRdDone = 1'b0;
            else if (rd && !wr && sel) begin
                mRdVal  = (off == 16'd1) ? status : 16'h0000;
                mRdDone = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        logic [15:0] drainExp [8];
        logic [15:0] rAddr;
        mInit = 1'b0;
        mRdDone = 1'b0;
        mHalted = 1'b0;
        drainExp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd9};

        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstValid", {15'b0, TxValid}, 16'h0);
        checkOutput("rstDataIn", DataIn, 16'h0);
        checkOutput("rstWait", {15'b0, Waitreq}, 16'h0);
        checkOutput("rstHalt", {15'b0, Halt}, 16'h0);

        applyStimulus(16'hFF00, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("pdHead1", TxData, 16'h1234);
        applyStimulus(16'hFF00, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("pdHead2", TxData, 16'hABCD);
        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("pdEmpty", {15'b0, TxValid}, 16'h0);

        for (int i = 0; i < 8; i++)
            applyStimulus(16'hFF00, 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFF00, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("stallWait", {15'b0, obsWait}, 16'h1);
        applyStimulus(16'hFF00, 16'h0009, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("stallPopWait", {15'b0, obsWait}, 16'h1);
        applyStimulus(16'hFF00, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("stallDone", {15'b0, obsWait}, 16'h0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("drainOrder", obsData, drainExp[k]);
        end
        checkOutput("drainEmpty", {15'b0, TxValid}, 16'h0);

        for (int i = 1; i <= 3; i++)
            applyStimulus(16'hFF00, 16'hA000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stRdWait", {15'b0, obsWait}, 16'h1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stRdDone", {15'b0, obsWait}, 16'h0);
        checkOutput("stRd3", obsDataIn, 16'h0300);
        applyStimulus(16'hFF00, 16'hA004, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFF00, 16'hA005, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFF02, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("flushValid", {15'b0, TxValid}, 16'h0);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stRdEmpty", obsDataIn, 16'h0001);
        for (int i = 0; i < 8; i++)
            applyStimulus(16'hFF00, 16'h00B0 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stRdFull", obsDataIn, 16'h0802);
        applyStimulus(16'hFF02, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);

        applyStimulus(16'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("unselWait", {15'b0, obsWait}, 16'h0);
        applyStimulus(16'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("unselData", obsDataIn, 16'h0);

        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstMidRead", DataIn, 16'h0);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("rdAfterRst", {15'b0, obsWait}, 16'h1);
        applyStimulus(16'hFF01, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    rAddr = 16'hFF00;
                2:       rAddr = 16'hFF01;
                3:       rAddr = 16'hFF02;
                4:       rAddr = 16'h0010;
                default: rAddr = 16'hFFFF;
            endcase
            applyStimulus(rAddr, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) != 0));
        end

`ifdef MMIO_HALT_EN
        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("haltSet", {15'b0, Halt}, 16'h1);
        applyStimulus(16'hFF00, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("haltNoPushWait", {15'b0, obsWait}, 16'h0);
        checkOutput("haltNoPush", {15'b0, TxValid}, 16'h0);
        applyStimulus(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("haltSticky", {15'b0, Halt}, 16'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
